dcache_dm: RTL

Direct-mapped, write-back, write-allocate data cache that answers the memory unit's `dmem_*` requests. It returns word data and a one-cycle `ufp_resp` pulse. It fills and evicts 256-bit lines over a burst-free line interface to the memory arbiter. State arrays are flop-based, so there are no SRAM macros.

---
 rtl/dcache_dm_pkg.sv | 20 ++
 rtl/dcache_array.sv | 57 +++++
 rtl/dcache_dm.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dcache_dm_pkg.sv
// rtl/dcache_dm_pkg.sv - shared cache types and constants
package rv32i_types;

    localparam int DCACHE_LINE_BITS = 256;
    localparam int DCACHE_OFFSET_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } dcache_state_t;

    // Places a 4-bit word byte mask at its byte lanes within a 32-byte line.
    function automatic logic [31:0] line_byte_en(input logic [2:0] word_sel,
                                                 input logic [3:0] mask);
        line_byte_en = 32'(mask) << {word_sel, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - flop-based per-set valid/dirty/tag/data store
module dcache_array
    import rv32i_types::*;
#(
    parameter int NUM_SETS  = 16,
    parameter int LINE_BITS = DCACHE_LINE_BITS,
    parameter int IDX_W     = $clog2(NUM_SETS),
    parameter int TAG_W     = 27 - IDX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IDX_W-1:0]       idx,
    output logic                   rd_valid,
    output logic                   rd_dirty,
    output logic [TAG_W-1:0]       rd_tag,
    output logic [LINE_BITS-1:0]   rd_line,
    input  logic                   we,
    input  logic [LINE_BITS/8-1:0] wr_be,
    input  logic [LINE_BITS-1:0]   wr_line,
    input  logic [TAG_W-1:0]       wr_tag,
    input  logic                   wr_valid,
    input  logic                   wr_dirty
);

    logic [NUM_SETS-1:0]  valid_q;
    logic [NUM_SETS-1:0]  dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_SETS];
    logic [LINE_BITS-1:0] data_q [NUM_SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            valid_q[idx] <= wr_valid;
            dirty_q[idx] <= wr_dirty;
        end
    end

    // Tag and data carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[idx] <= wr_tag;
            for (int b = 0; b < LINE_BITS / 8; b++) begin
                if (wr_be[b]) begin
                    data_q[idx][b*8 +: 8] <= wr_line[b*8 +: 8];
                end
            end
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];

endmodule

// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-back write-allocate data cache
module dcache_dm
    import rv32i_types::*;
#(
    parameter int NUM_SETS  = 16,
    parameter int LINE_BITS = DCACHE_LINE_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          ufp_addr,
    input  logic [3:0]           ufp_rmask,
    input  logic [3:0]           ufp_wmask,
    input  logic [31:0]          ufp_wdata,
    output logic [31:0]          ufp_rdata,
    output logic                 ufp_resp,
    output logic [31:0]          dfp_addr,
    output logic                 dfp_read,
    output logic                 dfp_write,
    output logic [LINE_BITS-1:0] dfp_wdata,
    input  logic [LINE_BITS-1:0] dfp_rdata,
    input  logic                 dfp_resp
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 27 - IDX_W;

    dcache_state_t state_q, state_d;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [2:0]       req_word;
    logic [3:0]       wmask_q;
    logic [31:0]      wdata_q;

    logic                   rd_valid, rd_dirty;
    logic [TAG_W-1:0]       rd_tag;
    logic [LINE_BITS-1:0]   rd_line;
    logic                   arr_we;
    logic [LINE_BITS/8-1:0] arr_be;
    logic [LINE_BITS-1:0]   arr_line;
    logic [TAG_W-1:0]       arr_tag;
    logic                   arr_valid, arr_dirty;

    logic        req_valid, hit, is_store;
    logic [31:0] cur_word;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^ufp_addr[1:0];
    assign req_valid = (|ufp_rmask) || (|ufp_wmask);
    assign is_store  = |wmask_q;
    assign hit       = rd_valid && (rd_tag == req_tag);
    assign cur_word  = rd_line[{req_word, 5'b00000} +: 32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture; only IDLE listens, so a dropped request is still served.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid) begin
            req_tag  <= ufp_addr[31:5+IDX_W];
            req_idx  <= ufp_addr[4+IDX_W:5];
            req_word <= ufp_addr[4:2];
            wmask_q  <= ufp_wmask;
            wdata_q  <= ufp_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        ufp_resp  = 1'b0;
        ufp_rdata = '0;
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
        dfp_addr  = '0;
        dfp_wdata = '0;
        arr_we    = 1'b0;
        arr_be    = '0;
        arr_line  = rd_line;
        arr_tag   = rd_tag;
        arr_valid = rd_valid;
        arr_dirty = rd_dirty;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    ufp_resp  = 1'b1;
                    ufp_rdata = cur_word;
                    state_d   = IDLE;
                    if (is_store) begin
                        arr_we    = 1'b1;
                        arr_be    = line_byte_en(req_word, wmask_q);
                        arr_line  = {(LINE_BITS/32){wdata_q}};
                        arr_dirty = 1'b1;
                    end
                end else if (rd_valid && rd_dirty) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                dfp_write = 1'b1;
                dfp_addr  = {rd_tag, req_idx, 5'b00000};
                dfp_wdata = rd_line;
                if (dfp_resp) begin
                    arr_we    = 1'b1;
                    arr_dirty = 1'b0;
                    state_d   = ALLOCATE;
                end
            end
            ALLOCATE: begin
                dfp_read = 1'b1;
                dfp_addr = {req_tag, req_idx, 5'b00000};
                if (dfp_resp) begin
                    arr_we    = 1'b1;
                    arr_be    = '1;
                    arr_line  = dfp_rdata;
                    arr_tag   = req_tag;
                    arr_valid = 1'b1;
                    arr_dirty = 1'b0;
                    state_d   = COMPARE;
                end
            end
        endcase
    end

    dcache_array #(
        .NUM_SETS  (NUM_SETS),
        .LINE_BITS (LINE_BITS),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .idx      (req_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (arr_we),
        .wr_be    (arr_be),
        .wr_line  (arr_line),
        .wr_tag   (arr_tag),
        .wr_valid (arr_valid),
        .wr_dirty (arr_dirty)
    );

endmodule
